// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmit multiplexer and the receive-side
// demultiplexer: TX state encoding, default baud divisor, frame byte order and
// the (addr, data) pair payload.
package uart_pkg;

  // 21.477 MHz / 115200 baud, truncated
  localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 186;

  localparam int unsigned UART_BYTE_W = 8;

  // Byte order within one frame on the wire
  localparam int unsigned FRAME_BYTE_ADDR = 0;
  localparam int unsigned FRAME_BYTE_DATA = 1;
  localparam int unsigned FRAME_BYTE_CSUM = 2;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef struct packed {
    logic [UART_BYTE_W-1:0] addr;
    logic [UART_BYTE_W-1:0] data;
  } uart_pair_t;

  // Frame checksum: byte sum of address and data, modulo 256
  function automatic logic [UART_BYTE_W-1:0] uart_checksum(
    input logic [UART_BYTE_W-1:0] a,
    input logic [UART_BYTE_W-1:0] d
  );
    return UART_BYTE_W'(a + d);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO for pending (addr, data) pairs.
// Ports: clk, reset_n (sync, active-low); push/wdata enqueue; pop dequeues the
// head presented combinationally on head_c; full/empty are registered flags;
// accept_c reports whether this cycle's push is taken (pop frees a slot first).
module uart_tx_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LOG2  = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head_c,
  output logic             accept_c,
  output logic             full,
  output logic             empty
);

  localparam int unsigned DEPTH = 1 << LOG2;
  localparam int unsigned PTR_W = LOG2 + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W-1:0] wr_ptr_nxt, rd_ptr_nxt;
  logic             do_pop;

  // Pop is evaluated first so a push while full and popping is accepted
  always_comb begin
    do_pop     = pop && !empty;
    accept_c   = push && (!full || do_pop);
    wr_ptr_nxt = wr_ptr + PTR_W'(accept_c);
    rd_ptr_nxt = rd_ptr + PTR_W'(do_pop);
    head_c     = mem[rd_ptr[LOG2-1:0]];
  end

  // Pointer and flag registers; the extra pointer MSB distinguishes full from empty
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      full   <= (wr_ptr_nxt[LOG2] != rd_ptr_nxt[LOG2]) &&
                (wr_ptr_nxt[LOG2-1:0] == rd_ptr_nxt[LOG2-1:0]);
      empty  <= (wr_ptr_nxt == rd_ptr_nxt);
    end
  end

  // Storage array
  always_ff @(posedge clk) begin
    if (reset_n && accept_c) begin
      mem[wr_ptr[LOG2-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/uart_mux_tx.sv
// UART address/data multiplexer, transmit side. Queues (addr, din) pairs and
// sends each as consecutive 8N1 bytes, address first, then data.
// Optional macro UART_MUX_TX_CHECKSUM_EN appends a third byte (addr + din) mod 256.
// Ports: clk; reset_n (sync, active-low); addr/din/write enqueue a pair;
// full (FIFO at capacity); busy (pending pairs or frame in flight);
// overflow (sticky, write dropped while full); tx (serial line, idle high).
module uart_mux_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int unsigned FIFO_LOG2    = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] addr,
  input  logic [7:0] din,
  input  logic       write,
  output logic       full,
  output logic       busy,
  output logic       overflow,
  output logic       tx
);

  localparam int unsigned CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned PAIR_W = $bits(uart_pair_t);
`ifdef UART_MUX_TX_CHECKSUM_EN
  localparam int unsigned SEL_W     = 2;
  localparam int unsigned LAST_BYTE = FRAME_BYTE_CSUM;
`else
  localparam int unsigned SEL_W     = 1;
  localparam int unsigned LAST_BYTE = FRAME_BYTE_DATA;
`endif

  tx_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       shift, shift_nxt;
  logic [7:0]       data_hold, data_hold_nxt;
  logic [SEL_W-1:0] byte_sel, byte_sel_nxt;
`ifdef UART_MUX_TX_CHECKSUM_EN
  logic [7:0]       csum_hold, csum_hold_nxt;
`endif
  logic             bit_end_c;
  logic             pop_c;
  logic             tx_c;
  logic             busy_c;

  uart_pair_t       wr_pair;
  uart_pair_t       head_c;
  logic             accept_c;
  logic             fifo_empty;

  assign wr_pair = '{addr: addr, data: din};

  uart_tx_fifo #(
    .WIDTH (PAIR_W),
    .LOG2  (FIFO_LOG2)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (write),
    .wdata    (wr_pair),
    .pop      (pop_c),
    .head_c   (head_c),
    .accept_c (accept_c),
    .full     (full),
    .empty    (fifo_empty)
  );

  // Next-state and line-level decode
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    bit_idx_nxt   = bit_idx;
    shift_nxt     = shift;
    data_hold_nxt = data_hold;
    byte_sel_nxt  = byte_sel;
`ifdef UART_MUX_TX_CHECKSUM_EN
    csum_hold_nxt = csum_hold;
`endif
    pop_c         = 1'b0;
    tx_c          = 1'b1;
    bit_end_c     = (cnt == CNT_W'(CLKS_PER_BIT - 1));

    case (state)
      TX_IDLE: begin
        if (!fifo_empty) begin
          pop_c         = 1'b1;
          shift_nxt     = head_c.addr;
          data_hold_nxt = head_c.data;
`ifdef UART_MUX_TX_CHECKSUM_EN
          csum_hold_nxt = uart_checksum(head_c.addr, head_c.data);
`endif
          byte_sel_nxt  = SEL_W'(FRAME_BYTE_ADDR);
          cnt_nxt       = '0;
          state_nxt     = TX_START;
        end
      end
      TX_START: begin
        tx_c = 1'b0;
        if (bit_end_c) begin
          cnt_nxt     = '0;
          bit_idx_nxt = 3'd0;
          state_nxt   = TX_DATA;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      TX_DATA: begin
        tx_c = shift[0];
        if (bit_end_c) begin
          cnt_nxt     = '0;
          shift_nxt   = {1'b0, shift[7:1]};
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_nxt = TX_STOP;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      TX_STOP: begin
        tx_c = 1'b1;
        if (bit_end_c) begin
          cnt_nxt = '0;
          if (byte_sel == SEL_W'(LAST_BYTE)) begin
            state_nxt = TX_IDLE;
          end else begin
`ifdef UART_MUX_TX_CHECKSUM_EN
            shift_nxt = (byte_sel == SEL_W'(FRAME_BYTE_ADDR)) ? data_hold : csum_hold;
`else
            shift_nxt = data_hold;
`endif
            byte_sel_nxt = byte_sel + SEL_W'(1);
            state_nxt    = TX_START;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = TX_IDLE;
      end
    endcase

    // Busy after this edge: a pop implies state_nxt leaves IDLE, so a
    // non-empty FIFO or an accepted push is enough to stay busy
    busy_c = (state_nxt != TX_IDLE) || !fifo_empty || accept_c;
  end

  // State and output registers; tx follows the current state one cycle later
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= TX_IDLE;
      cnt       <= '0;
      bit_idx   <= 3'd0;
      shift     <= 8'd0;
      data_hold <= 8'd0;
      byte_sel  <= '0;
`ifdef UART_MUX_TX_CHECKSUM_EN
      csum_hold <= 8'd0;
`endif
      tx        <= 1'b1;
      busy      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      shift     <= shift_nxt;
      data_hold <= data_hold_nxt;
      byte_sel  <= byte_sel_nxt;
`ifdef UART_MUX_TX_CHECKSUM_EN
      csum_hold <= csum_hold_nxt;
`endif
      tx        <= tx_c;
      busy      <= busy_c;
      overflow  <= overflow | (write & ~accept_c);
    end
  end

endmodule

// File: tb/tb_uart_mux_tx.sv
// Scoreboard bench for uart_mux_tx: a pair-level model predicts pop times,
// FIFO occupancy and the expected frames; a UART monitor decodes tx and checks
// each frame's start cycle and bit pattern against the expected queue.
module tb_uart_mux_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned LOG2  = 2;
  localparam int          DEPTH = 1 << LOG2;
`ifdef UART_MUX_TX_CHECKSUM_EN
  localparam int          NB    = 3;
`else
  localparam int          NB    = 2;
`endif
  localparam int          NBITS     = NB * 10;
  localparam int          FRAME_CYC = NBITS * int'(CPB);

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    int         start;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       write = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] din = 8'h00;
  logic       full, busy, overflow, tx;

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;

  logic [15:0] mq[$];
  exp_t        exp_q[$];
  int          m_free_at = 0;
  logic        m_ovf = 1'b0;
  logic        m_full = 1'b0;
  logic        m_busy = 1'b0;

  uart_mux_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_LOG2    (LOG2)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .addr     (addr),
    .din      (din),
    .write    (write),
    .full     (full),
    .busy     (busy),
    .overflow (overflow),
    .tx       (tx)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Wire image of one frame, LSB-first per byte: start 0, 8 data bits, stop 1
  function automatic logic [29:0] frame_bits(input logic [7:0] a, input logic [7:0] d);
    logic [7:0]  bytes [3];
    logic [29:0] r;
    r = '0;
    bytes[0] = a;
    bytes[1] = d;
    bytes[2] = 8'(a + d);
    for (int b = 0; b < NB; b++) begin
      r[b*10] = 1'b0;
      for (int i = 0; i < 8; i++) r[b*10 + 1 + i] = bytes[b][i];
      r[b*10 + 9] = 1'b1;
    end
    return r;
  endfunction

  // Pair-level model: a pop happens when pairs are queued and the previous
  // frame plus one idle cycle has elapsed; tx falls the cycle after the pop
  always @(posedge clk) begin
    cyc++;
    if (!reset_n) begin
      mq.delete();
      exp_q.delete();
      m_free_at = 0;
      m_ovf     = 1'b0;
    end else begin
      if (mq.size() > 0 && cyc >= m_free_at) begin
        logic [15:0] h;
        h = mq.pop_front();
        exp_q.push_back('{h[15:8], h[7:0], cyc + 1});
        m_free_at = cyc + FRAME_CYC + 1;
      end
      if (write) begin
        if (mq.size() < DEPTH) mq.push_back({addr, din});
        else m_ovf = 1'b1;
      end
    end
    m_full = (mq.size() == DEPTH);
    m_busy = (mq.size() > 0) || (cyc < m_free_at - 1);
  end

  // Per-cycle flag checks
  always @(negedge clk) begin
    if (cyc > 0) begin
      cmp("full", full, m_full);
      cmp("busy", busy, m_busy);
      cmp("overflow", overflow, m_ovf);
    end
  end

  // UART monitor: decode whole frames from tx and score them
  initial begin : monitor
    exp_t        e;
    logic [29:0] got;
    int          start;
    bit          aborted;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && tx === 1'b0) begin
        start   = cyc;
        aborted = 1'b0;
        got     = '0;
        for (int k = 0; k < NBITS; k++) begin
          while (!aborted && cyc < start + k * int'(CPB) + int'(CPB) / 2) begin
            @(negedge clk);
            if (reset_n !== 1'b1) aborted = 1'b1;
          end
          if (aborted) break;
          got[k] = tx;
        end
        if (!aborted) begin
          cmp("frame_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp("frame_start", start, e.start);
            cmp("frame_bits", 32'(got), 32'(frame_bits(e.a, e.d)));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] d);
    write = 1'b1;
    addr  = a;
    din   = d;
    tick();
    write = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    cmp("idle_timeout", 32'(busy !== 1'b0), 32'd0);
    repeat (3) tick();
  endtask

  initial begin : stimulus
    repeat (3) tick();
    cmp("rst_tx", tx, 1'b1);
    cmp("rst_full", full, 1'b0);
    cmp("rst_busy", busy, 1'b0);
    cmp("rst_overflow", overflow, 1'b0);
    reset_n = 1'b1;
    tick();

    // Single pair and launch latency
    send(8'h35, 8'hA5);
    cmp("lat_tx_n", tx, 1'b1);
    tick();
    cmp("lat_tx_n1", tx, 1'b1);
    tick();
    cmp("lat_tx_n2", tx, 1'b0);
    wait_idle(400);
    send(8'hF0, 8'h20);
    wait_idle(400);

    // Burst fills FIFO behind a frame in flight, then push on the pop cycle
    send(8'h11, 8'h22);
    repeat (5) tick();
    for (int i = 0; i < 4; i++) send(8'(8'hA0 + i), 8'(8'h50 + i));
    cmp("burst_full", full, 1'b1);
    cmp("burst_overflow", overflow, 1'b0);
    while (cyc + 1 < m_free_at) tick();
    send(8'hC3, 8'h3C);
    cmp("pop_push_full", full, 1'b1);
    cmp("pop_push_overflow", overflow, 1'b0);
    wait_idle(1000);

    // Fifth write into a full FIFO is dropped
    send(8'hEE, 8'h77);
    repeat (3) tick();
    for (int i = 1; i <= 5; i++) send(8'(i), 8'(8'h10 + i));
    cmp("ovf_set", overflow, 1'b1);
    wait_idle(1000);

    // Reset mid-frame during the address byte's data bits
    do_reset();
    cmp("ovf_cleared", overflow, 1'b0);
    send(8'h5A, 8'hC6);
    repeat (1 + 4 * CPB) tick();
    do_reset();
    cmp("abort_tx", tx, 1'b1);
    cmp("abort_busy", busy, 1'b0);
    cmp("abort_full", full, 1'b0);
    send(8'h96, 8'h69);
    wait_idle(400);

    // Random traffic: sparse, then dense enough to overflow
    for (int i = 0; i < 1500; i++) begin
      write = (i < 1000) ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 3) == 0);
      addr  = 8'($urandom);
      din   = 8'($urandom);
      tick();
    end
    write = 1'b0;
    wait_idle(3000);
    cmp("frames_pending", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_mux_tx.md
Name: uart_mux_tx

Overview:
- Transmit-side counterpart of the UART address/data demultiplexer.
- Accepts (addr, data) pairs from the NES top level, queues them in a small FIFO and serialises each pair onto the TX line as consecutive 8N1 bytes: address byte first, data byte second.
- Replaces the constant-high TX tie-off so that debug and status values (loader state, RAM failure, controller echo) reach the host.

Parameters:
CLKS_PER_BIT, 186, clk cycles per UART bit (21.477 MHz / 115200 baud, truncated)
FIFO_LOG2, 2, log2 of FIFO depth in pairs (depth 4)

Ports:
clk  in  1  system clock (single clock domain)
reset_n  in  1  synchronous, active-low reset
addr  in  8  address byte of the pair to send
din  in  8  data byte of the pair to send
write  in  1  push {addr,din} into FIFO this cycle
full  out  1  FIFO holds 2^FIFO_LOG2 pairs
busy  out  1  FIFO non-empty or a frame is in flight
overflow  out  1  sticky; set when write is asserted while full
tx  out  1  serial output, idle high

Behaviour:
- Reset (reset_n=0 at a clk edge): tx=1, full=0, busy=0, overflow=0; FIFO pointers cleared; FSM=IDLE; bit and cycle counters cleared. Reset mid-frame aborts the frame; tx returns high on the next edge.
- FIFO: registered write. write && !full stores {addr,din} at the write pointer. write && full drops the pair and sets overflow. overflow clears only on reset.
- Simultaneous write and pop while full: pop first, so the push is accepted and full stays 1.
- Pointers are FIFO_LOG2+1 bits wide, so wrap-around is handled by the extra MSB. full = MSBs differ and low bits equal; empty = pointers equal.
- FSM states IDLE, START, DATA, STOP. Each bit lasts exactly CLKS_PER_BIT cycles via a cycle counter that counts 0..CLKS_PER_BIT-1.
  - IDLE: tx=1. When FIFO is non-empty, pop the head, latch shift register = addr, byte_sel=0, go to START.
  - START: tx=0 for one bit time, then DATA with bit_idx=0.
  - DATA: tx=shift[0], LSB first. At each bit end, shift right and increment bit_idx. After bit 7, go to STOP.
  - STOP: tx=1 for one bit time. Then:
    - byte_sel=0: load the latched data byte, byte_sel=1, go to START.
    - Last byte done: go to IDLE. If the FIFO is still non-empty, IDLE pops on its next cycle, giving exactly 1 extra idle cycle between frames.
- Latency: write sampled at edge N. FIFO non-empty after edge N. IDLE pops at edge N+1. tx falls at edge N+2.
- Frame length is 2×10×CLKS_PER_BIT cycles, plus 1 IDLE cycle.
- busy = !empty || state!=IDLE.

Optional Feature:
- Macro UART_MUX_TX_CHECKSUM_EN.
- Defined: each frame carries a third 8N1 byte, (addr + din) mod 256, sent after the data byte. byte_sel widens to 2 bits and values 0/1/2 select addr/data/checksum.
- Undefined: frames are exactly two bytes and no checksum logic is synthesised.

Decomposition:
- Shared package uart_pkg holds:
  - state enum TX_IDLE/TX_START/TX_DATA/TX_STOP
  - constant UART_DEFAULT_CLKS_PER_BIT=186
  - the frame byte-order constants
  These are shared with the receive-side demultiplexer.
- One natural sub-module: uart_tx_fifo, a parameterised synchronous FIFO with push/pop/full/empty, kept separate so it can be verified standalone.

Test Plan:
- Single pair, CLKS_PER_BIT=4: write addr=0x35, din=0xA5 once.
  - tx falls 2 cycles later.
  - Sampled bits: 0,1,0,1,0,1,1,0,0,1 (0x35 LSB first, then stop).
  - Then 0,1,0,1,0,0,1,0,1,1 (0xA5).
  - busy drops after 80 cycles.
- Burst of 4 writes on consecutive cycles: full rises after the 4th.
  - All 4 pairs are transmitted in order.
  - Exactly 1 idle cycle at tx=1 separates each frame.
  - overflow stays 0.
- 5 consecutive writes (0x01..0x05) while the first frame has not yet popped: overflow=1 and the 5th pair is never transmitted.
- write while full on the same cycle as the IDLE pop: the pair is accepted, full stays 1, overflow stays 0.
- reset_n=0 during the DATA state of the addr byte: tx=1 next cycle, busy=0, FIFO empty. A new write after reset sends a clean frame.
- With UART_MUX_TX_CHECKSUM_EN: pair 0xF0/0x20 produces a third byte 0x10, and the frame is 3 bytes long.
